// File: rtl/page_free_list_manager_pkg.sv
// Shared types and constants for the free-page list manager.
// Optional double-free protection is enabled with PAGE_MGR_DBL_FREE_CHECK_EN.
package page_free_list_manager_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned ERR_PULSE_CYCLES = 1;

endpackage

// File: rtl/page_free_list_manager_next_ptr_ram.sv
// Next-pointer storage for the free list: one synchronous write port, one asynchronous read port.
module page_free_list_manager_next_ptr_ram #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [AW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [AW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [AW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/page_free_list_manager.sv
// Free-page manager: linked free list with init sweep, one alloc and one free per cycle.
// Define PAGE_MGR_DBL_FREE_CHECK_EN to reject frees of pages already in the list.
module page_free_list_manager
  import page_free_list_manager_pkg::*;
#(
  parameter int unsigned PAGE_NUM_LOG = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_req,
  output logic [PAGE_NUM_LOG-1:0] alloc_addr,
  input  logic                    free_req,
  input  logic [PAGE_NUM_LOG-1:0] free_addr,
  output logic [PAGE_NUM_LOG-1:0] last_addr,
  output logic [PAGE_NUM_LOG:0]   count,
  output logic                    empty,
  output logic                    init_done,
  output logic                    overflow_err,
  output logic                    dbl_free_err
);

  localparam int unsigned AW       = PAGE_NUM_LOG;
  localparam int unsigned PAGE_NUM = 1 << AW;
  localparam int unsigned CW       = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(PAGE_NUM);

  state_e        state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          init_done_q, init_done_d;
  logic          ovf_q, ovf_d;
  logic          dbl_q, dbl_d;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_wdata, head_next;
  logic          alloc_ok, free_ok, dbl_hit;
`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
  logic [PAGE_NUM-1:0] bitmap_q, bitmap_d;
`endif

  page_free_list_manager_next_ptr_ram #(.AW(AW)) u_next_ptr_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (head_q),
    .rdata_o (head_next)
  );

  // Next-state, RAM write mux and accept/reject decisions.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    empty_d     = empty_q;
    init_done_d = init_done_q;
    ovf_d       = 1'b0;
    dbl_d       = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = tail_q;
    ram_wdata   = free_addr;
    alloc_ok    = 1'b0;
    free_ok     = 1'b0;
    dbl_hit     = 1'b0;
`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
    bitmap_d    = bitmap_q;
`endif
    case (state_q)
      ST_INIT: begin
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_wdata  = init_cnt_q + AW'(1);
        init_cnt_d = init_cnt_q + AW'(1);
`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
        bitmap_d[init_cnt_q] = 1'b1;
`endif
        if (init_cnt_q == AW'(PAGE_NUM - 1)) begin
          state_d     = ST_RUN;
          count_d     = FULL;
          empty_d     = 1'b0;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        alloc_ok = alloc_req && (count_q != '0);
`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
        // An alloc of the same page this cycle removes it first, so that free is legal.
        dbl_hit = bitmap_q[free_addr] && !(alloc_ok && (head_q == free_addr));
`endif
        ovf_d   = free_req && (count_q == FULL);
        dbl_d   = free_req && !ovf_d && dbl_hit;
        free_ok = free_req && !ovf_d && !dbl_hit;
        if (alloc_ok) begin
          head_d = head_next;
`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
          bitmap_d[head_q] = 1'b0;
`endif
        end
        if (free_ok) begin
          tail_d = free_addr;
`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
          bitmap_d[free_addr] = 1'b1;
`endif
          // List ends up holding only the freed page: no link to write.
          if ((count_q == '0) || ((count_q == CW'(1)) && alloc_ok)) head_d = free_addr;
          else ram_we = 1'b1;
        end
        count_d = count_q + CW'(free_ok) - CW'(alloc_ok);
        empty_d = (count_d == '0);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      head_q      <= '0;
      tail_q      <= AW'(PAGE_NUM - 1);
      count_q     <= '0;
      empty_q     <= 1'b1;
      init_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      dbl_q       <= 1'b0;
`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
      bitmap_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      init_done_q <= init_done_d;
      ovf_q       <= ovf_d;
      dbl_q       <= dbl_d;
`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
      bitmap_q    <= bitmap_d;
`endif
    end
  end

  assign alloc_addr   = head_q;
  assign last_addr    = tail_q;
  assign count        = count_q;
  assign empty        = empty_q;
  assign init_done    = init_done_q;
  assign overflow_err = ovf_q;
  assign dbl_free_err = dbl_q;

endmodule

// File: tb/tb_page_free_list_manager.sv
// Bench for page_free_list_manager: directed scenarios plus random traffic against a queue model.
// Double-free scenarios run only when PAGE_MGR_DBL_FREE_CHECK_EN is defined.
module tb_page_free_list_manager;

  localparam int unsigned AW = 4;
  localparam int unsigned N  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_req = 1'b0;
  logic          free_req = 1'b0;
  logic [AW-1:0] free_addr = '0;
  logic [AW-1:0] alloc_addr, last_addr;
  logic [AW:0]   count;
  logic          empty, init_done, overflow_err, dbl_free_err;

  int q[$];
  int n_checks = 0;
  int n_errors = 0;

  page_free_list_manager #(.PAGE_NUM_LOG(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_addr   (alloc_addr),
    .free_req     (free_req),
    .free_addr    (free_addr),
    .last_addr    (last_addr),
    .count        (count),
    .empty        (empty),
    .init_done    (init_done),
    .overflow_err (overflow_err),
    .dbl_free_err (dbl_free_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_list(int p);
    foreach (q[i]) if (q[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick_absent();
    int start = int'($urandom_range(N - 1));
    for (int k = 0; k < int'(N); k++)
      if (!in_list((start + k) % N)) return (start + k) % N;
    return start;
  endfunction

  task automatic check_outputs(input bit exp_ovf, input bit exp_dbl);
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("init_done", 32'(init_done), 32'd1);
    chk("overflow_err", 32'(overflow_err), 32'(exp_ovf));
    chk("dbl_free_err", 32'(dbl_free_err), 32'(exp_dbl));
    if (q.size() != 0) begin
      chk("alloc_addr", 32'(alloc_addr), 32'(q[0]));
      chk("last_addr", 32'(last_addr), 32'(q[q.size() - 1]));
    end
  endtask

  // One cycle of traffic; the model applies alloc before free, which covers every same-cycle rule.
  task automatic step(input bit a, input bit f, input int addr);
    bit a_ok, ovf, dbl, dbl_hit;
    @(negedge clk);
    alloc_req = a;
    free_req  = f;
    free_addr = AW'(addr);
    a_ok    = a && (q.size() != 0);
    ovf     = f && (q.size() == N);
    dbl_hit = 1'b0;
`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
    dbl_hit = in_list(addr) && !(a_ok && (q[0] == addr));
`endif
    dbl = f && !ovf && dbl_hit;
    @(posedge clk);
    #1;
    if (a_ok) void'(q.pop_front());
    if (f && !ovf && !dbl) q.push_back(addr);
    check_outputs(ovf, dbl);
    alloc_req = 1'b0;
    free_req  = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_overflow_err", 32'(overflow_err), 32'd0);
    chk("rst_dbl_free_err", 32'(dbl_free_err), 32'd0);
    chk("rst_alloc_addr", 32'(alloc_addr), 32'd0);
    chk("rst_last_addr", 32'(last_addr), 32'(N - 1));
  endtask

  // Release reset with requests held high; they must be ignored throughout the sweep.
  task automatic release_and_init();
    int cyc = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    alloc_req = 1'b1;
    free_req  = 1'b1;
    free_addr = AW'($urandom_range(N - 1));
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (init_done) break;
    end
    alloc_req = 1'b0;
    free_req  = 1'b0;
    chk("init_cycles", 32'(cyc), 32'd16);
    q.delete();
    for (int i = 0; i < int'(N); i++) q.push_back(i);
    check_outputs(1'b0, 1'b0);
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      int addr = pick_absent();
`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
      if ($urandom_range(3) == 0) addr = int'($urandom_range(N - 1));
`endif
      step(1'($urandom_range(1)), 1'($urandom_range(1)), addr);
    end
  endtask

  initial begin
    // T1: reset and init sweep
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    release_and_init();

    // T2: drain the list, then one alloc on empty
    for (int i = 0; i < int'(N); i++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    // T3: frees from empty, then allocs in FIFO order
    step(1'b0, 1'b1, 7);
    step(1'b0, 1'b1, 3);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    // T4: alloc+free at count 1 and at count 8
    step(1'b0, 1'b1, 5);
    step(1'b1, 1'b1, 9);
    while (q.size() < 8) step(1'b0, 1'b1, pick_absent());
    step(1'b1, 1'b1, pick_absent());

    // T5: overflow at full, then the pulse must drop
    while (q.size() < N) step(1'b0, 1'b1, pick_absent());
    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 2);

    random_traffic(300);

    // T6: reset in the middle of traffic
    random_traffic(20);
    @(negedge clk);
    rst_n     = 1'b0;
    alloc_req = 1'b1;
    free_req  = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    release_and_init();

`ifdef PAGE_MGR_DBL_FREE_CHECK_EN
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 4);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1);
`endif

    random_traffic(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
